sync_fifo_ram: RTL and testbench

SYNC_FIFO_RAM -- requirements
Module: sync_fifo_ram

---
 rtl/sync_fifo_ram.sv | 104 ++++++++++
 tb/tb_sync_fifo_ram.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO on a dual-port register array with a registered read port,
// occupancy count, level flags and sticky overflow/underflow error flags.
module sync_fifo_ram #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int AFULL_LEVEL = 2**ADDR_WIDTH - 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH   = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH+1)'(AFULL_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;

    // Flags come straight from the registered count so they move with it.
    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= AFULL_C);

    // Acceptance uses pre-edge flags: full+both reads only, empty+both writes only.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        rd_valid_d  = rd_acc;
        overflow_d  = overflow_q  | (wr_en & full);
        underflow_d = underflow_q | (rd_en & empty);

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            dout_d   = mem_q[rd_ptr_q];
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; writes during reset are discarded.
    always_ff @(posedge clk) begin
        if (reset_n && wr_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign dout      = dout_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Directed testbench for sync_fifo_ram at default parameters (16 x 8, afull at 14).
module tb_sync_fifo_ram;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] din = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] dout;
    logic       rd_valid, full, empty, almost_full, overflow, underflow;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;

    sync_fifo_ram dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic r);
        wr_en = w; din = d; rd_en = r;
        step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wr_en = 1'b1; din = 8'h77; rd_en = 1'b1;
        step();
        reset_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", almost_full); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err_flags got %b exp 00", {overflow, underflow}); end
        drive(1'b0, 8'h00, 1'b0);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_discard_count got %0d exp 0", count); end
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, exp_d[i], 1'b0);
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_no_valid got %b exp 0", rd_valid); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            checks++; if (dout !== exp_d[i]) begin errors++; $display("FAIL basic_dout%0d got %h exp %h", i, dout, exp_d[i]); end
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid%0d got %b exp 1", i, rd_valid); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty got %b exp 1", empty); end
        drive(1'b0, 8'h00, 1'b0);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b exp 0", rd_valid); end
        checks++; if (dout !== 8'h33) begin errors++; $display("FAIL basic_dout_hold got %h exp 33", dout); end
    endtask

    task automatic test_underflow();
        do_reset();
        drive(1'b0, 8'h00, 1'b1);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL udf_valid got %b exp 0", rd_valid); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL udf_dout got %h exp 00", dout); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_flag got %b exp 1", underflow); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL udf_count got %0d exp 0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL udf_ovf got %b exp 0", overflow); end
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_sticky got %b exp 1", underflow); end
    endtask

    task automatic test_full();
        logic exp_af;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'hA0 + 8'(i), 1'b0);
            exp_af = (i + 1 >= 14);
            checks++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL full_count%0d got %0d exp %0d", i, count, i + 1); end
            checks++; if (almost_full !== exp_af) begin errors++; $display("FAIL full_afull%0d got %b exp %b", i, almost_full, exp_af); end
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_early got %b exp 0", overflow); end
        drive(1'b1, 8'hFF, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_ovf got %b exp 1", overflow); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_ovf_count got %0d exp 16", count); end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            checks++; if (dout !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL full_rd%0d got %h exp %h", i, dout, 8'hA0 + 8'(i)); end
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL full_rdv%0d got %b exp 1", i, rd_valid); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drained got %b exp 1", empty); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_ovf_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_simultaneous_edges();
        do_reset();
        for (int i = 0; i < 16; i++) drive(1'b1, 8'hB0 + 8'(i), 1'b0);
        drive(1'b1, 8'hEE, 1'b1);
        checks++; if (count !== 5'd15) begin errors++; $display("FAIL both_full_count got %0d exp 15", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL both_full_ovf got %b exp 1", overflow); end
        checks++; if (dout !== 8'hB0) begin errors++; $display("FAIL both_full_dout got %h exp b0", dout); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL both_full_valid got %b exp 1", rd_valid); end
        for (int i = 1; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            checks++; if (dout !== 8'hB0 + 8'(i)) begin errors++; $display("FAIL both_full_drain%0d got %h exp %h", i, dout, 8'hB0 + 8'(i)); end
        end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL both_empty_pre_udf got %b exp 0", underflow); end
        drive(1'b1, 8'h5A, 1'b1);
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL both_empty_count got %0d exp 1", count); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL both_empty_udf got %b exp 1", underflow); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL both_empty_valid got %b exp 0", rd_valid); end
        drive(1'b0, 8'h00, 1'b1);
        checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL both_empty_data got %h exp 5a", dout); end
    endtask

    task automatic test_back_to_back();
        int r = 0;
        int w = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hC0 + 8'(w), 1'b0);
            w++;
        end
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 8'hC0 + 8'(w), 1'b1);
            w++;
            checks++; if (count !== 5'd5) begin errors++; $display("FAIL b2b_count%0d got %0d exp 5", i, count); end
            checks++; if (dout !== 8'hC0 + 8'(r)) begin errors++; $display("FAIL b2b_dout%0d got %h exp %h", i, dout, 8'hC0 + 8'(r)); end
            r++;
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            checks++; if (dout !== 8'hC0 + 8'(r)) begin errors++; $display("FAIL b2b_drain%0d got %h exp %h", i, dout, 8'hC0 + 8'(r)); end
            r++;
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b exp 1", empty); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h40 + 8'(i), 1'b0);
        checks++; if (count !== 5'd7) begin errors++; $display("FAIL mid_pre_count got %0d exp 7", count); end
        reset_n = 1'b0; wr_en = 1'b1; din = 8'h99; rd_en = 1'b0;
        step();
        reset_n = 1'b1;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b exp 1", empty); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL mid_err_flags got %b exp 00", {overflow, underflow}); end
        drive(1'b1, 8'h3C, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL mid_first_word got %h exp 3c", dout); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL mid_valid got %b exp 1", rd_valid); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_end_empty got %b exp 1", empty); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_full();
        test_simultaneous_edges();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
